operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with all state changing only on the rising edge of clk.
REQ-002 The ports SHALL be as follows, clock and reset first:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- MC  in  1  instruction in progress; low aborts.
- AdAs  in  3  {Ad, As[1:0]} of the current instruction.
- BW  in  1  1 = byte operation, 0 = word operation.
- CALC_out  in  16  effective address from the address calculator.
- CALC_done  in  1  one-cycle pulse, CALC_out valid.
- MDB_out  in  16  memory read data, valid the cycle after MR.
- WB_req  in  1  execute stage requests destination write-back.
- WB_data  in  16  write-back value.
- MAB  out  16  memory address bus.
- MDB_in  out  16  memory write data.
- MR  out  1  memory read strobe.
- MW  out  1  memory write strobe.
- BE  out  2  byte enables for writes, {hi, lo}.
- SRC_op  out  16  fetched source operand.
- DST_op  out  16  fetched destination operand.
- OPS_valid  out  1  one-cycle pulse, operands ready.
- WB_ack  out  1  one-cycle pulse, write-back issued.
- ALIGN_ERR  out  1  sticky misalignment flag (see Configuration).

Function
REQ-003 Address capture SHALL occur while MC=1 and CALC_done=1, in any state.
- If AdAs[0]=1 and no source address has been captured in this instruction: latch CALC_out into SA and set sa_pend.
- Otherwise: latch CALC_out into DA and set da_pend.
REQ-004 The states SHALL be IDLE, SRD, SCAP, DRD, DCAP, DONE, WBW and WR.
REQ-005 From IDLE, the block SHALL go to SRD if sa_pend=1, else to DRD if da_pend=1; when both are pending, source has priority.
REQ-006 In SRD the block SHALL drive MAB=SA and MR=1 for exactly one cycle, then go to SCAP.
REQ-007 In SCAP the block SHALL load SRC_op from MDB_out and clear sa_pend; it SHALL then go to DRD if AdAs[2]=1, else to DONE.
REQ-008 The block SHALL stay in DRD with MR=0 until da_pend=1.
- When da_pend=1, it SHALL drive MAB=DA and MR=1 for one cycle, then go to DCAP.
REQ-009 In DCAP the block SHALL load DST_op from MDB_out, clear da_pend and go to DONE.
REQ-010 In DONE the block SHALL assert OPS_valid for one cycle.
- It SHALL then go to WBW if AdAs[2]=1, else to IDLE.
REQ-011 In WBW the block SHALL wait for WB_req=1, then go to WR.
REQ-012 In WR the block SHALL, for one cycle, drive MAB=DA, MW=1, the write data and byte enables (per REQ-015), and WB_ack=1; it SHALL then go to IDLE.
REQ-013 Byte reads (BW=1) SHALL zero-extend the selected lane: MDB_out[15:8] if address bit 0 = 1, else MDB_out[7:0].
REQ-014 Word reads (BW=0) SHALL load all 16 bits.
REQ-015 Byte writes SHALL drive MDB_in={WB_data[7:0],WB_data[7:0]}, with BE=2'b10 for an odd address and 2'b01 for an even address.
REQ-016 Word writes SHALL drive MDB_in=WB_data and BE=2'b11.
REQ-017 Outside SRD, DRD and WR, the block SHALL drive MR=0, MW=0, BE=0 and MAB=0.
REQ-018 Latency for AdAs=001 with CALC_done at cycle t SHALL be: MR at t+1, OPS_valid at t+3.
REQ-019 For AdAs=101, the second CALC_done arriving at t+2 SHALL be captured, with the DRD read at t+3 and OPS_valid at t+5.
REQ-020 When MC=0 on any edge, the block SHALL:
- force IDLE;
- clear sa_pend, da_pend and the source-captured flag;
- deassert MR, MW, OPS_valid and WB_ack;
- leave SRC_op and DST_op holding their values.
REQ-021 When CALC_done and the SCAP write of SRC_op occur in the same cycle, the DA capture SHALL take effect and sa_pend SHALL clear.
REQ-022 WB_req SHALL be ignored outside WBW.
REQ-023 CALC_done SHALL be ignored when MC=0.

Reset
REQ-024 When rst_n=0 at a clock edge, the block SHALL:
- enter IDLE;
- set SA, DA, SRC_op, DST_op, MAB and MDB_in to 0;
- set MR, MW, BE, OPS_valid, WB_ack and ALIGN_ERR to 0;
- clear all pending flags.
REQ-025 Reset SHALL take priority over MC and all other inputs, including in the middle of any read or write.

Configuration
REQ-026 With macro OPF_ALIGN_CHECK_EN defined, a word access (BW=0) issued with address bit 0 = 1 SHALL:
- set ALIGN_ERR=1 (sticky until reset);
- drive MAB with bit 0 forced to 0.
REQ-027 Without OPF_ALIGN_CHECK_EN, MAB SHALL carry the address unchanged and ALIGN_ERR SHALL be constant 0.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- AdAs=001, BW=0, CALC_done with CALC_out=0x0200 at t, MDB_out=0x1234 at t+2 -> MAB=0x0200 with MR at t+1; SRC_op=0x1234 and OPS_valid at t+3; no MW.
- AdAs=101, pulses 0x0200 (t) then 0x0300 (t+2), read data 0xAAAA then 0x5555 -> reads at t+1 and t+3; SRC_op=0xAAAA, DST_op=0x5555, OPS_valid at t+5; then WB_req with WB_data=0xBEEF -> MAB=0x0300, MW=1, BE=11, WB_ack one cycle.
- AdAs=100, BW=1, CALC_out=0x0301, MDB_out=0xC3A5 -> DST_op=0x00C3; write-back with WB_data=0x0077 -> MDB_in=0x7777, BE=10.
- AdAs=101, MC dropped at t+2 -> IDLE next cycle; no DRD read; no OPS_valid.
- rst_n=0 during WBW -> all outputs 0 next cycle; subsequent WB_req ignored.
- With OPF_ALIGN_CHECK_EN, word read at 0x0201 -> MAB=0x0200, ALIGN_ERR=1, held until reset; without the macro -> MAB=0x0201, ALIGN_ERR=0.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch: reads source/destination memory operands for the current
// instruction and issues the destination write-back. Optional macro: OPF_ALIGN_CHECK_EN.
module operand_fetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MC,
    input  logic [2:0]  AdAs,
    input  logic        BW,
    input  logic [15:0] CALC_out,
    input  logic        CALC_done,
    input  logic [15:0] MDB_out,
    input  logic        WB_req,
    input  logic [15:0] WB_data,
    output logic [15:0] MAB,
    output logic [15:0] MDB_in,
    output logic        MR,
    output logic        MW,
    output logic [1:0]  BE,
    output logic [15:0] SRC_op,
    output logic [15:0] DST_op,
    output logic        OPS_valid,
    output logic        WB_ack,
    output logic        ALIGN_ERR
);
    typedef enum logic [2:0] {IDLE, SRD, SCAP, DRD, DCAP, DONE, WBW, WR} state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [15:0] r_sa, r_da, w_sa_nx, w_da_nx;
    logic        r_sa_pend, r_da_pend, r_src_cap;
    logic        w_sa_pend_nx, w_da_pend_nx, w_src_cap_nx;
    logic        w_cap_sa, w_cap_da, w_finish;
    logic        w_rd_s, w_rd_d, w_wr, w_acc, w_mis;
    logic [15:0] w_addr, w_mab_nx, w_wdata_nx, w_src_rd, w_dst_rd;
    logic [1:0]  w_be_nx;
    logic [15:0] r_mab, r_mdb_in, r_src_op, r_dst_op;
    logic [1:0]  r_be;
    logic        r_mr, r_mw, r_ops_valid, r_wb_ack, r_align_err;

    // Next-state and next-register values; bus outputs are registered from these.
    always_comb begin
        w_cap_sa = MC && CALC_done && AdAs[0] && !r_src_cap;
        w_cap_da = MC && CALC_done && !w_cap_sa;
        w_sa_nx  = w_cap_sa ? CALC_out : r_sa;
        w_da_nx  = w_cap_da ? CALC_out : r_da;
        w_finish = ((r_state == DONE) && !AdAs[2]) || (r_state == WR);

        w_sa_pend_nx = r_sa_pend;
        if (!MC)                  w_sa_pend_nx = 1'b0;
        else if (w_cap_sa)        w_sa_pend_nx = 1'b1;
        else if (r_state == SCAP) w_sa_pend_nx = 1'b0;

        w_da_pend_nx = r_da_pend;
        if (!MC)                  w_da_pend_nx = 1'b0;
        else if (w_cap_da)        w_da_pend_nx = 1'b1;
        else if (r_state == DCAP) w_da_pend_nx = 1'b0;

        w_src_cap_nx = r_src_cap;
        if (!MC)           w_src_cap_nx = 1'b0;
        else if (w_cap_sa) w_src_cap_nx = 1'b1;
        else if (w_finish) w_src_cap_nx = 1'b0;

        w_state_nx = r_state;
        case (r_state)
            IDLE: begin
                if (w_sa_pend_nx)      w_state_nx = SRD;
                else if (w_da_pend_nx) w_state_nx = DRD;
            end
            SRD:  w_state_nx = SCAP;
            SCAP: w_state_nx = AdAs[2] ? DRD : DONE;
            DRD:  w_state_nx = r_da_pend ? DCAP : DRD;
            DCAP: w_state_nx = DONE;
            DONE: w_state_nx = AdAs[2] ? WBW : IDLE;
            WBW:  w_state_nx = WB_req ? WR : WBW;
            WR:   w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
        if (!MC) w_state_nx = IDLE;

        // A DRD cycle only drives the bus once the destination address is known.
        w_rd_s = (w_state_nx == SRD);
        w_rd_d = (w_state_nx == DRD) && w_da_pend_nx;
        w_wr   = (w_state_nx == WR);
        w_acc  = w_rd_s || w_rd_d || w_wr;
        w_addr = w_rd_s ? w_sa_nx : w_da_nx;
`ifdef OPF_ALIGN_CHECK_EN
        w_mis  = w_acc && !BW && w_addr[0];
`else
        w_mis  = 1'b0;
`endif
        w_mab_nx   = w_acc ? (w_addr & ~{15'd0, w_mis}) : 16'd0;
        w_be_nx    = !w_wr ? 2'b00 : (!BW ? 2'b11 : (w_da_nx[0] ? 2'b10 : 2'b01));
        w_wdata_nx = !w_wr ? 16'd0 : (BW ? {WB_data[7:0], WB_data[7:0]} : WB_data);

        w_src_rd = !BW ? MDB_out : (r_sa[0] ? {8'h00, MDB_out[15:8]} : {8'h00, MDB_out[7:0]});
        w_dst_rd = !BW ? MDB_out : (r_da[0] ? {8'h00, MDB_out[15:8]} : {8'h00, MDB_out[7:0]});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sa        <= 16'd0;
            r_da        <= 16'd0;
            r_sa_pend   <= 1'b0;
            r_da_pend   <= 1'b0;
            r_src_cap   <= 1'b0;
            r_src_op    <= 16'd0;
            r_dst_op    <= 16'd0;
            r_mab       <= 16'd0;
            r_mdb_in    <= 16'd0;
            r_mr        <= 1'b0;
            r_mw        <= 1'b0;
            r_be        <= 2'b00;
            r_ops_valid <= 1'b0;
            r_wb_ack    <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_sa        <= w_sa_nx;
            r_da        <= w_da_nx;
            r_sa_pend   <= w_sa_pend_nx;
            r_da_pend   <= w_da_pend_nx;
            r_src_cap   <= w_src_cap_nx;
            r_mab       <= w_mab_nx;
            r_mdb_in    <= w_wdata_nx;
            r_mr        <= w_rd_s || w_rd_d;
            r_mw        <= w_wr;
            r_be        <= w_be_nx;
            r_ops_valid <= (w_state_nx == DONE);
            r_wb_ack    <= w_wr;
            r_align_err <= r_align_err || w_mis;
            if (MC && (r_state == SCAP)) r_src_op <= w_src_rd;
            if (MC && (r_state == DCAP)) r_dst_op <= w_dst_rd;
        end
    end

    assign MAB       = r_mab;
    assign MDB_in    = r_mdb_in;
    assign MR        = r_mr;
    assign MW        = r_mw;
    assign BE        = r_be;
    assign SRC_op    = r_src_op;
    assign DST_op    = r_dst_op;
    assign OPS_valid = r_ops_valid;
    assign WB_ack    = r_wb_ack;
    assign ALIGN_ERR = r_align_err;
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios then randomized instructions,
// each checked cycle by cycle against a behavioural model of the fetch rules.
`timescale 1ns/1ps
module tb_operand_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MC = 1'b0;
    logic [2:0]  AdAs = 3'b000;
    logic        BW = 1'b0;
    logic [15:0] CALC_out = 16'd0;
    logic        CALC_done = 1'b0;
    logic [15:0] MDB_out = 16'd0;
    logic        WB_req = 1'b0;
    logic [15:0] WB_data = 16'd0;
    logic [15:0] MAB, MDB_in, SRC_op, DST_op;
    logic        MR, MW, OPS_valid, WB_ack, ALIGN_ERR;
    logic [1:0]  BE;

    int          n_tests = 0;
    int          n_fail = 0;
    logic        exp_align = 1'b0;
    logic [15:0] exp_q[$];

    operand_fetch dut (
        .clk(clk), .rst_n(rst_n), .MC(MC), .AdAs(AdAs), .BW(BW),
        .CALC_out(CALC_out), .CALC_done(CALC_done), .MDB_out(MDB_out),
        .WB_req(WB_req), .WB_data(WB_data), .MAB(MAB), .MDB_in(MDB_in),
        .MR(MR), .MW(MW), .BE(BE), .SRC_op(SRC_op), .DST_op(DST_op),
        .OPS_valid(OPS_valid), .WB_ack(WB_ack), .ALIGN_ERR(ALIGN_ERR)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference rules, written as plain arithmetic on addresses and data.
    function automatic logic [15:0] m_read(input logic [15:0] w, input logic [15:0] a, input logic bw);
        if (!bw) return w;
        if (a % 16'd2 == 16'd1) return w / 16'd256;
        return w % 16'd256;
    endfunction

    function automatic logic m_mis(input logic [15:0] a, input logic bw);
`ifdef OPF_ALIGN_CHECK_EN
        return !bw && (a % 16'd2 == 16'd1);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] m_mab(input logic [15:0] a, input logic bw);
        return m_mis(a, bw) ? a - 16'd1 : a;
    endfunction

    function automatic logic [15:0] m_wdata(input logic [15:0] d, input logic bw);
        return bw ? (d % 16'd256) * 16'd257 : d;
    endfunction

    function automatic logic [1:0] m_be(input logic [15:0] a, input logic bw);
        if (!bw) return 2'd3;
        return (a % 16'd2 == 16'd1) ? 2'd2 : 2'd1;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_MAB"}, MAB, 16'd0);
        check({tag, "_MDB_in"}, MDB_in, 16'd0);
        check1({tag, "_MR"}, MR, 1'b0);
        check1({tag, "_MW"}, MW, 1'b0);
        check({tag, "_BE"}, 16'(BE), 16'd0);
        check1({tag, "_OPS_valid"}, OPS_valid, 1'b0);
        check1({tag, "_WB_ack"}, WB_ack, 1'b0);
        check1({tag, "_ALIGN_ERR"}, ALIGN_ERR, exp_align);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; MC = 1'b0; CALC_done = 1'b0; WB_req = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        exp_align = 1'b0;
    endtask

    // One instruction: adas is 001, 101 or 100; gap is the delay of the second
    // address pulse for 101, wdly the wait before the write-back request.
    task automatic do_instr(input logic [2:0] adas, input logic bw,
                            input logic [15:0] a1, input logic [15:0] a2,
                            input logic [15:0] d1, input logic [15:0] d2,
                            input logic [15:0] wbd, input int gap, input int wdly);
        int rd_s, rd_d, ov, wq, wr, last;
        logic [15:0] sa, da, sd, dd, exp_mab, addr;
        logic acc_rd, acc_wr;
        rd_s = -1; rd_d = -1; wq = -1; wr = -1;
        sa = 16'd0; da = 16'd0; sd = 16'd0; dd = 16'd0;
        if (adas[0]) begin
            sa = a1; sd = d1; rd_s = 1;
            if (adas[2]) begin
                da = a2; dd = d2;
                rd_d = (gap + 1 > 3) ? gap + 1 : 3;
            end
        end else begin
            da = a1; dd = d1; rd_d = 1;
        end
        ov = (rd_d > 0) ? rd_d + 2 : rd_s + 2;
        if (adas[2]) begin
            wq = ov + 1 + wdly; wr = wq + 1; last = wr + 1;
        end else begin
            last = ov + 1;
        end
        exp_q.delete();
        if (rd_s > 0) exp_q.push_back(m_mab(sa, bw));
        if (rd_d > 0) exp_q.push_back(m_mab(da, bw));
        if (wr > 0)   exp_q.push_back(m_mab(da, bw));

        MC = 1'b1; AdAs = adas; BW = bw;
        for (int c = 0; c <= last; c++) begin
            CALC_done = (c == 0) || (adas == 3'b101 && c == gap);
            CALC_out  = (c == 0) ? a1 : (CALC_done ? a2 : 16'($urandom));
            if (rd_s > 0 && c == rd_s + 1)      MDB_out = sd;
            else if (rd_d > 0 && c == rd_d + 1) MDB_out = dd;
            else                                MDB_out = 16'($urandom);
            WB_req  = (c == wq) || (c <= ov && $urandom_range(0, 3) == 0);
            WB_data = (c == wq) ? wbd : 16'($urandom);

            acc_rd = (c == rd_s) || (c == rd_d);
            acc_wr = (c == wr);
            exp_mab = 16'd0;
            if (acc_rd || acc_wr) begin
                addr = (c == rd_s) ? sa : da;
                exp_mab = exp_q.pop_front();
                if (m_mis(addr, bw)) exp_align = 1'b1;
            end
            check1($sformatf("MR c%0d", c), MR, acc_rd);
            check1($sformatf("MW c%0d", c), MW, acc_wr);
            check($sformatf("MAB c%0d", c), MAB, exp_mab);
            check($sformatf("BE c%0d", c), 16'(BE), acc_wr ? 16'(m_be(da, bw)) : 16'd0);
            check($sformatf("MDB_in c%0d", c), MDB_in, acc_wr ? m_wdata(wbd, bw) : 16'd0);
            check1($sformatf("OPS_valid c%0d", c), OPS_valid, c == ov);
            check1($sformatf("WB_ack c%0d", c), WB_ack, acc_wr);
            check1($sformatf("ALIGN_ERR c%0d", c), ALIGN_ERR, exp_align);
            if (c == ov && adas[0]) check("SRC_op", SRC_op, m_read(sd, sa, bw));
            if (c == ov && adas[2]) check("DST_op", DST_op, m_read(dd, da, bw));
            step();
        end
        CALC_done = 1'b0; WB_req = 1'b0; MC = 1'b0;
        step();
    endtask

    initial begin
        do_reset();
        check_idle("reset");
        check("reset_SRC_op", SRC_op, 16'd0);
        check("reset_DST_op", DST_op, 16'd0);

        // Word source read, then two-operand with write-back, then byte destination.
        do_instr(3'b001, 1'b0, 16'h0200, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1, 0);
        do_instr(3'b101, 1'b0, 16'h0200, 16'h0300, 16'hAAAA, 16'h5555, 16'hBEEF, 2, 0);
        do_instr(3'b100, 1'b1, 16'h0301, 16'h0000, 16'hC3A5, 16'h0000, 16'h0077, 1, 0);

        // Instruction abort in SCAP: no destination read, operands held.
        MC = 1'b1; AdAs = 3'b101; BW = 1'b0; CALC_done = 1'b1; CALC_out = 16'h0200;
        step();
        CALC_done = 1'b0;
        check1("drop_MR", MR, 1'b1);
        check("drop_MAB", MAB, 16'h0200);
        step();
        MC = 1'b0; CALC_done = 1'b1; CALC_out = 16'h0300;
        step();
        CALC_done = 1'b0;
        for (int c = 3; c <= 8; c++) begin
            if (c == 5) MC = 1'b1;
            check_idle($sformatf("drop c%0d", c));
            check($sformatf("drop_SRC c%0d", c), SRC_op, 16'hAAAA);
            check($sformatf("drop_DST c%0d", c), DST_op, 16'h00C3);
            step();
        end
        MC = 1'b0;
        step();

        // Reset while waiting for write-back.
        MC = 1'b1; AdAs = 3'b100; BW = 1'b0; CALC_done = 1'b1; CALC_out = 16'h0400;
        step();
        CALC_done = 1'b0;
        step();
        MDB_out = 16'h1111;
        step();
        check1("rstwb_OPS_valid", OPS_valid, 1'b1);
        step();
        check("rstwb_DST_before", DST_op, 16'h1111);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_align = 1'b0;
        check_idle("rstwb");
        check("rstwb_SRC_op", SRC_op, 16'd0);
        check("rstwb_DST_op", DST_op, 16'd0);
        WB_req = 1'b1; WB_data = 16'hDEAD;
        for (int c = 6; c <= 9; c++) begin
            step();
            check_idle($sformatf("rstwb_ignore c%0d", c));
        end
        WB_req = 1'b0; MC = 1'b0;
        step();

        // Misaligned word read; the flag must stay set until reset.
        do_instr(3'b001, 1'b0, 16'h0201, 16'h0000, 16'h4321, 16'h0000, 16'h0000, 1, 0);
        do_instr(3'b001, 1'b1, 16'h0100, 16'h0000, 16'h9876, 16'h0000, 16'h0000, 1, 0);
        check1("align_hold", ALIGN_ERR, exp_align);
        do_reset();
        check1("align_cleared", ALIGN_ERR, 1'b0);

        for (int n = 0; n < 24; n++) begin
            logic [2:0] adas;
            case ($urandom_range(0, 2))
                0:       adas = 3'b001;
                1:       adas = 3'b101;
                default: adas = 3'b100;
            endcase
            do_instr(adas, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                     16'($urandom), 16'($urandom), 16'($urandom),
                     $urandom_range(1, 4), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
